// File: rtl/pipe_stage_skid.sv
// Generic two-entry elastic pipeline stage (main + skid register) with valid/ready
// handshake, stall-vector hold/bubble semantics, flush and a saturating bubble counter.
module pipe_stage_skid #(
  parameter int                WIDTH     = 64,
  parameter int                CTRL_W    = 6,
  parameter int                STAGE     = 2,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             acc, dep;
  logic             unused_stall;

  assign unused_stall = ^stall;

  assign in_ready   = !skid_v_q;
  assign out_valid  = main_v_q;
  assign out_data   = main_v_q ? main_data_q : NOP_VALUE;
  assign occupancy  = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign bubble_cnt = bubble_cnt_q;

  assign acc = in_valid & in_ready & !stall[STAGE] & !flush;
  assign dep = main_v_q & out_ready & !stall[STAGE+1] & !flush;

  // Skid is only ever occupied while main is, so main_v_q alone decides "empty".
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_data_d = NOP_VALUE;
      skid_data_d = NOP_VALUE;
    end else if (!main_v_q) begin
      if (acc) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
      end
    end else if (!skid_v_q) begin
      if (acc && dep) begin
        main_data_d = in_data;
      end else if (acc) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end else if (dep) begin
        main_v_d = 1'b0;
      end
    end else if (dep) begin
      main_data_d = skid_data_q;
      skid_v_d    = 1'b0;
      skid_data_d = NOP_VALUE;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_v_q && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q     <= 1'b0;
      skid_v_q     <= 1'b0;
      main_data_q  <= NOP_VALUE;
      skid_data_q  <= NOP_VALUE;
      bubble_cnt_q <= '0;
    end else begin
      main_v_q     <= main_v_d;
      skid_v_q     <= skid_v_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
- One generic 2-entry elastic stage carrying an opaque payload of WIDTH bits. It uses a valid/ready handshake and keeps the existing stall-vector semantics (hold vs. bubble insertion).
- It adds a flush input (branch/jump redirect) and a saturating bubble counter for performance monitoring.
- It is instantiated between any two stages. The controller drives `stall` and `flush`.

Parameters:
- WIDTH, 64: payload width in bits.
- CTRL_W, 6: width of the stall control vector.
- STAGE, 2: index of this stage's upstream bit in `stall`. The downstream bit is STAGE+1 and must be < CTRL_W.
- NOP_VALUE, 0: payload presented on `out_data` whenever `out_valid` = 0 (encodes ALU_NOP/OP_NOP/ZeroWord/WriteDisable).
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- stall  in  CTRL_W  pipeline stall vector, 1 = Stop
- flush  in  1  discard all held entries and the current input
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  payload valid to downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  downstream payload
- occupancy  out  2  entries held (0..2)
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid = 0

Behaviour:
Storage
- Main register (main_v, main_d) drives the outputs.
- Skid register (skid_v, skid_d) absorbs one extra payload.
- out_valid = main_v.
- out_data = main_d when main_v = 1, else NOP_VALUE.
- in_ready = !skid_v (registered, no combinational path from out_ready).
- occupancy = main_v + skid_v.

Transfer qualifiers (combinational)
- acc = in_valid & in_ready & !stall[STAGE] & !flush
- dep = main_v & out_ready & !stall[STAGE+1] & !flush

State updates per cycle, in priority order
1. rst = 0 (asynchronous): main_v = skid_v = 0, main_d = skid_d = NOP_VALUE, bubble_cnt = 0. Outputs then read out_valid = 0, out_data = NOP_VALUE, in_ready = 1, occupancy = 0. Reset mid-transfer drops all data.
2. flush = 1: main_v = skid_v = 0, both data registers = NOP_VALUE. Input is not accepted even if in_valid & in_ready. Stall is ignored.
3. Otherwise, by state:
   - Empty (occupancy 0): if acc, main <= in, giving 1-cycle latency in to out.
   - One (main only):
     - acc & dep: main <= in.
     - acc & !dep: skid <= in.
     - !acc & dep: main_v <= 0.
     - neither: hold.
   - Full (main + skid): acc is impossible (in_ready = 0).
     - dep: main <= skid, skid_v <= 0.
     - else hold.

Stall semantics
- stall[STAGE]=1 and stall[STAGE+1]=0: no accept, downstream may drain. When main drains, out_valid drops and the NOP bubble appears (legacy bubble insertion).
- stall[STAGE]=1 and stall[STAGE+1]=1: full hold, no accept or depart.
- stall[STAGE]=0 and stall[STAGE+1]=1: accept only; fills skid, then in_ready drops.

Ordering and counter
- Order is strictly FIFO; no payload is duplicated or lost except by flush/rst.
- bubble_cnt increments each clock with out_valid = 0 and rst = 1. It saturates at 2^CNT_W−1 and is cleared only by rst, not by flush.

Test Plan:
- Reset: rst=0 for 3 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=0, in_ready=1, occupancy=0, bubble_cnt=0. Release; first accepted payload appears on the next edge.
- Streaming: stall=0, out_ready=1, in_data=1,2,3,4 on consecutive cycles → out_data=1,2,3,4 one cycle later, occupancy stays 1, in_ready stays 1.
- Back-pressure: out_ready=0 while sending 0x11, 0x22 → occupancy=2, in_ready=0, 0x33 held upstream. out_ready=1 → 0x11, then 0x22, then 0x33 accepted; order preserved.
- Bubble: main holds 0x55, stall[2]=1, stall[3]=0, out_ready=1 → 0x55 departs, next cycle out_valid=0, out_data=NOP_VALUE. bubble_cnt increments each stalled cycle.
- Hold: stall[2]=stall[3]=1 with occupancy 2 → outputs and occupancy frozen for 5 cycles, no accept.
- Flush: occupancy 2 (0x66, 0x77), flush=1 with in_valid=1, in_data=0x88 → next cycle occupancy=0, out_valid=0, in_ready=1, 0x88 never appears. With CNT_W=2, 5 empty cycles leave bubble_cnt=3 (saturated).
